// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-capable arbiter sharing one FIFO write port between NUM_REQ requesters
// Ports: clk/reset (sync, active-high); req/req_data from requesters; grant one-hot back to them;
// fifo_full/fifo_A_full from the FIFO; fifo_write_en/fifo_write_data to the FIFO;
// owner_valid/owner_id expose the current or most recent burst owner.
module fifo_wr_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_BIT_SIZE = 8,
    parameter int MAX_BURST     = 4,
    parameter int ID_W          = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*DATA_BIT_SIZE-1:0] req_data,
    output logic [NUM_REQ-1:0]               grant,
    input  logic                             fifo_full,
    input  logic                             fifo_A_full,
    output logic                             fifo_write_en,
    output logic [DATA_BIT_SIZE-1:0]         fifo_write_data,
    output logic                             owner_valid,
    output logic [ID_W-1:0]                  owner_id
);
    typedef enum logic {IDLE, BURST} state_t;
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [3:0]      burst_cnt_q, burst_cnt_d;
    logic            gnt_en;
    logic [ID_W-1:0] gnt_idx;
    logic            own_req;
    logic [ID_W:0]   search;

    // Pointer arithmetic wraps at NUM_REQ, not 2**ID_W.
    function automatic logic [ID_W-1:0] inc(input logic [ID_W-1:0] p);
        return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
    endfunction

    function automatic logic req_bit(input logic [NUM_REQ-1:0] r, input logic [ID_W-1:0] p);
        logic b;
        b = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) if (int'(p) == i) b = r[i];
        return b;
    endfunction

    // Returns {found, index}; scanning from the far end lets the offset closest to p win.
    function automatic logic [ID_W:0] pick(input logic [NUM_REQ-1:0] r, input logic [ID_W-1:0] p);
        logic [ID_W:0] res;
        int s;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            s = int'(p) + i;
            if (s >= NUM_REQ) s = s - NUM_REQ;
            if (r[s]) res = {1'b1, ID_W'(s)};
        end
        return res;
    endfunction

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        gnt_en      = 1'b0;
        gnt_idx     = owner_q;
        own_req     = req_bit(req, owner_q);
        // A dropped burst re-arbitrates this cycle from the slot after the old owner.
        search      = pick(req, (state_q == BURST) ? inc(owner_q) : rr_ptr_q);
        if (!reset && !fifo_full) begin
            if (state_q == BURST && own_req) begin
                gnt_en      = 1'b1;
                burst_cnt_d = burst_cnt_q + 4'd1;
                if (burst_cnt_d == BURST_LIM || fifo_A_full) begin
                    state_d  = IDLE;
                    rr_ptr_d = inc(owner_q);
                end
            end else begin
                if (state_q == BURST) begin
                    state_d  = IDLE;
                    rr_ptr_d = inc(owner_q);
                end
                if (search[ID_W]) begin
                    gnt_en      = 1'b1;
                    gnt_idx     = search[ID_W-1:0];
                    owner_d     = gnt_idx;
                    burst_cnt_d = 4'd1;
                    if (MAX_BURST > 1 && !fifo_A_full) state_d = BURST;
                    else rr_ptr_d = inc(gnt_idx);
                end
            end
        end
    end

    always_comb begin
        fifo_write_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = gnt_en && (int'(gnt_idx) == i);
            fifo_write_data = fifo_write_data | (grant[i] ? req_data[i*DATA_BIT_SIZE +: DATA_BIT_SIZE] : '0);
        end
        fifo_write_en = gnt_en;
    end

    assign owner_valid = (state_q == BURST);
    assign owner_id    = owner_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench for fifo_wr_arbiter with directed vectors
module tb_fifo_wr_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  grant;
    logic        fifo_full = 1'b0;
    logic        fifo_A_full = 1'b0;
    logic        fifo_write_en;
    logic [7:0]  fifo_write_data;
    logic        owner_valid;
    logic [1:0]  owner_id;

    typedef struct {
        int         cyc;
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t       q[$];
    logic [7:0] d[4];
    int         cyc = 0;
    int         checks = 0;
    int         passed = 0;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_BIT_SIZE(8), .MAX_BURST(4), .ID_W(2)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .grant(grant),
        .fifo_full(fifo_full), .fifo_A_full(fifo_A_full), .fifo_write_en(fifo_write_en),
        .fifo_write_data(fifo_write_data), .owner_valid(owner_valid), .owner_id(owner_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_write_en) begin
            exp_t e;
            checks++;
            if (q.size() == 0) begin
                $display("FAIL write: unexpected write cyc=%0d grant=%b data=%h", cyc, grant, fifo_write_data);
            end else begin
                e = q.pop_front();
                if (e.cyc !== cyc || grant !== 4'(1 << e.idx) || fifo_write_data !== e.data)
                    $display("FAIL write: got cyc=%0d grant=%b data=%h, want cyc=%0d grant=%b data=%h",
                             cyc, grant, fifo_write_data, e.cyc, 4'(1 << e.idx), e.data);
                else passed++;
            end
        end
    end

    task automatic step(input logic rst, input logic [3:0] r, input logic full, input logic af,
                        input int exp, input int ov);
        @(posedge clk);
        #1;
        reset = rst;
        req = r;
        fifo_full = full;
        fifo_A_full = af;
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = d[i];
        if (exp >= 0) begin
            q.push_back('{cyc, exp, d[exp]});
            d[exp] = d[exp] + 8'd1;
        end
        @(negedge clk);
        if (ov >= 0) begin
            checks++;
            if (owner_valid !== ov[0])
                $display("FAIL owner_valid: cyc=%0d got %b want %b", cyc, owner_valid, ov[0]);
            else passed++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) d[i] = 8'(i * 16);
        step(1, 4'hF, 0, 0, -1, -1);
        step(1, 4'hF, 0, 0, -1, 0);
        for (int k = 0; k < 5; k++) step(0, 4'h0, 0, 0, -1, 0);
        for (int k = 0; k < 17; k++) step(0, 4'hF, 0, 0, (k / 4) % 4, (k % 4 == 0) ? 0 : 1);
        step(0, 4'h0, 0, 0, -1, 1);
        step(0, 4'b0100, 0, 0, 2, 0);
        step(0, 4'b0100, 0, 0, 2, 1);
        step(0, 4'b0001, 0, 0, 0, 1);
        step(0, 4'h0, 0, 0, -1, 1);
        step(0, 4'h0, 0, 0, -1, 0);
        for (int k = 0; k < 6; k++) step(0, 4'b1010, 0, 1, (k % 2 == 1) ? 3 : 1, 0);
        step(0, 4'h0, 0, 0, -1, 0);
        step(0, 4'b0001, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 4'b0001, 1, 0, -1, 1);
        for (int k = 0; k < 3; k++) step(0, 4'b0001, 0, 0, 0, 1);
        step(0, 4'b0001, 0, 0, 0, 0);
        step(0, 4'h0, 0, 0, -1, 1);
        step(0, 4'h0, 0, 0, -1, 0);
        step(0, 4'b1000, 0, 0, 3, 0);
        step(1, 4'b1000, 0, 0, -1, -1);
        step(0, 4'b1000, 0, 0, 3, 0);
        step(0, 4'h0, 0, 0, -1, 1);
        step(0, 4'h0, 0, 0, -1, 0);
        checks++;
        if (q.size() != 0) $display("FAIL drain: %0d expected writes never seen, want 0", q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one write port of the team's FIFO between NUM_REQ requesters.
- Sits between the cache-side producers (fill, writeback, snoop response, ...) and the FIFO's write_en/write_data.
- Honours the FIFO's full and A_full flags.
- Supports bounded bursts so one requester can stream consecutive entries without losing its slot.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_BIT_SIZE, 8, width of one FIFO entry.
- MAX_BURST, 4, max consecutive grants to one owner before forced rotation (1..15).
- ID_W, 2, width of requester index; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester write request; bit i belongs to requester i.
- req_data  in  NUM_REQ*DATA_BIT_SIZE  requester i data in bits [i*DATA_BIT_SIZE +: DATA_BIT_SIZE].
- grant  out  NUM_REQ  one-hot; requester i's data is written this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_A_full  in  1  FIFO almost-full flag.
- fifo_write_en  out  1  FIFO write strobe.
- fifo_write_data  out  DATA_BIT_SIZE  FIFO write data.
- owner_valid  out  1  a burst owner is held (state BURST).
- owner_id  out  ID_W  current or most recent burst owner.

Behaviour:
- Registered state:
  - rr_ptr (ID_W): highest-priority index.
  - state: IDLE or BURST.
  - owner_id.
  - burst_cnt (4 bits).
- Reset values: rr_ptr=0, state=IDLE, owner_id=0, burst_cnt=0, owner_valid=0.
  - grant, fifo_write_en and fifo_write_data are all 0 in the reset cycle, regardless of req.
- grant is combinational from registered state plus the current req/fifo_full. Zero-cycle latency: data presented with req is written in the cycle grant is high.
- Requester handshake:
  - A requester holds req and req_data stable until it sees grant.
  - Each grant cycle consumes exactly one entry.
  - Dropping req without a grant is legal (request withdrawn, nothing written).
- fifo_write_en = |grant.
- fifo_write_data = req_data slice of the granted index, or 0 when there is no grant.
- fifo_full=1: grant=0, no state change (burst_cnt, rr_ptr and owner hold).
- IDLE, fifo_full=0:
  - Grant the first set req bit searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Call it k.
  - On grant: owner_id<=k, burst_cnt<=1.
  - If MAX_BURST>1 and fifo_A_full=0: state<=BURST.
  - Otherwise: stay IDLE, rr_ptr<=(k+1) mod NUM_REQ.
  - If no req is set: nothing changes.
- BURST, fifo_full=0:
  - If req[owner_id]=1: grant owner_id, burst_cnt<=burst_cnt+1.
    - If burst_cnt+1==MAX_BURST, or fifo_A_full=1: state<=IDLE, rr_ptr<=(owner_id+1) mod NUM_REQ.
  - If req[owner_id]=0: state<=IDLE, rr_ptr<=(owner_id+1) mod NUM_REQ.
    - In this same cycle, arbitrate as IDLE starting at the new pointer. No bubble when other requesters wait.
    - The new arbitration excludes the old owner only through pointer order; the old owner is lowest priority.
- BURST with fifo_full=1: stays in BURST; the burst resumes when full deasserts.
- Wrap-around: pointer arithmetic is modulo NUM_REQ, not 2**ID_W. Indices >= NUM_REQ are never granted.
- fifo_A_full sampled high ends any burst after the current grant. Under A_full, at most one grant per requester per rotation.
- Fairness: a continuously requesting requester is granted within (NUM_REQ-1)*MAX_BURST+1 non-full cycles.
- Reset mid-burst: next cycle is IDLE with rr_ptr=0 and no grant during the reset cycle. No entry is written twice.
- owner_valid=1 iff state==BURST.
- owner_id keeps its last value in IDLE.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles → grant=0, fifo_write_en=0, owner_valid=0 throughout.
- req=4'b1111, each requester streams a counter, fifo_full=0, A_full=0, MAX_BURST=4 → grants 0,0,0,0,1,1,1,1,2,...,3, then back to 0. 16 writes in 16 cycles, data order matches.
- Requester 2 alone holds req for 2 cycles, then drops it while req[0]=1 → grants 2,2,0 with no idle cycle between. rr_ptr=3 after the drop. The next arbitration picks 0 via wrap.
- req=4'b1010 with fifo_A_full=1 constantly → alternating grants 1,3,1,3, owner_valid never 1.
- req=4'b0001, fifo_full pulses high in cycle 2 of a burst for 3 cycles → write_en low for 3 cycles. Burst continues with burst_cnt 2→3→4 and ends at MAX_BURST; exactly 4 writes total before rotation.
- Assert reset in cycle 2 of a burst by requester 3 → next cycle IDLE. With req=4'b1000 the grant goes to 3 after a pointer search from 0; no duplicate write in the reset cycle.
